// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions for the ID stage.
//   - opcode constants for the supported instruction classes
//   - alu_op_e   : ALU operation selector carried to EX
//   - imm_type_e : immediate format selector for id_stage_imm_gen
//   - ctrl_t     : control bundle registered into ID/EX
//   - alu_op_from_funct : funct3/funct7 -> ALU operation
package riscv_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
    } alu_op_e;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;

    typedef struct packed {
        alu_op_e    alu_op;
        logic       alu_src_imm;
        logic       alu_src_pc;
        logic       mem_read;
        logic       mem_write;
        logic [2:0] mem_size;
        logic       reg_write;
        logic       mem_to_reg;
        logic       branch;
        logic       jump;
    } ctrl_t;

    // alt is instr[30]; it selects SUB only for register-register ops,
    // but selects SRA for both SRA and SRAI.
    function automatic alu_op_e alu_op_from_funct(input logic [2:0] f3,
                                                  input logic       alt,
                                                  input logic       is_reg);
        case (f3)
            3'b000:  return (is_reg && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// ID/EX pipeline register bundle, driven by id_stage and read by EX.
//   ex_valid_o    : ID/EX holds a valid instruction
//   ex_pc_o       : PC of the held instruction
//   ex_rs1_data_o : operand 1 after write-back bypass
//   ex_rs2_data_o : operand 2 after write-back bypass
//   ex_imm_o      : sign-extended immediate
//   ex_rs1_o/ex_rs2_o/ex_rd_o : register indices for EX forwarding / WB
//   ex_ctrl_o     : control bundle (all zero for bubbles)
//   ex_illegal_o  : unsupported opcode, executed as NOP
interface id_stage_if
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32
);
    logic            ex_valid_o;
    logic [XLEN-1:0] ex_pc_o;
    logic [XLEN-1:0] ex_rs1_data_o;
    logic [XLEN-1:0] ex_rs2_data_o;
    logic [XLEN-1:0] ex_imm_o;
    logic [4:0]      ex_rs1_o;
    logic [4:0]      ex_rs2_o;
    logic [4:0]      ex_rd_o;
    ctrl_t           ex_ctrl_o;
    logic            ex_illegal_o;

    modport master (
        output ex_valid_o, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o,
               ex_rs1_o, ex_rs2_o, ex_rd_o, ex_ctrl_o, ex_illegal_o
    );

    modport slave (
        input  ex_valid_o, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o,
               ex_rs1_o, ex_rs2_o, ex_rd_o, ex_ctrl_o, ex_illegal_o
    );
endinterface

// File: rtl/id_stage_imm_gen.sv
// Immediate generator: combinational (instruction, format) -> 32-bit
// sign-extended immediate. The opcode bits are not needed here.
//   instr_i    : instruction bits [31:7]
//   imm_type_i : immediate format
//   imm_o      : sign-extended immediate
module id_stage_imm_gen
    import riscv_pkg::*;
(
    input  logic [31:7] instr_i,
    input  imm_type_e   imm_type_i,
    output logic [31:0] imm_o
);
    always_comb begin
        case (imm_type_i)
            IMM_S:   imm_o = {{21{instr_i[31]}}, instr_i[30:25], instr_i[11:7]};
            IMM_B:   imm_o = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25],
                              instr_i[11:8], 1'b0};
            IMM_U:   imm_o = {instr_i[31:12], 12'b0};
            IMM_J:   imm_o = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20],
                              instr_i[30:21], 1'b0};
            default: imm_o = {{21{instr_i[31]}}, instr_i[30:20]};
        endcase
    end
endmodule

// File: rtl/id_stage.sv
// Decode stage plus ID/EX pipeline register of the 5-stage RV32I core.
//   clk_i, reset_i           : clock, asynchronous active-high reset
//   id_valid_i/instr_i/pc_i  : IF/ID contents
//   rf_raddr*_o, rf_rdata*_i : register-file read port (combinational)
//   wb_regwrite_i/rd_i/wdata_i : write-back port, bypassed into operands
//   flush_i                  : kill the ID instruction (taken branch in EX)
//   ex_stall_i               : EX/MEM busy, hold ID/EX
//   if_stall_o               : hold PC and IF/ID
//   ex                       : ID/EX register bundle (id_stage_if.master)
module id_stage
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN   = 32,
    parameter logic [XLEN-1:0] RST_PC = '0
)
(
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            id_valid_i,
    input  logic [31:0]     id_instr_i,
    input  logic [XLEN-1:0] id_pc_i,
    output logic [4:0]      rf_raddr1_o,
    output logic [4:0]      rf_raddr2_o,
    input  logic [XLEN-1:0] rf_rdata1_i,
    input  logic [XLEN-1:0] rf_rdata2_i,
    input  logic            wb_regwrite_i,
    input  logic [4:0]      wb_rd_i,
    input  logic [XLEN-1:0] wb_wdata_i,
    input  logic            flush_i,
    input  logic            ex_stall_i,
    output logic            if_stall_o,
    id_stage_if.master      ex
);
    logic [6:0]      opcode;
    logic [4:0]      rs1_a, rs2_a, rd_a;
    logic [2:0]      funct3;
    ctrl_t           ctrl_d;
    imm_type_e       imm_type;
    logic            illegal_d;
    logic            use_rs1, use_rs2;
    logic [31:0]     imm32;
    logic [XLEN-1:0] op1_d, op2_d;
    logic            load_use;

    logic            valid_q;
    logic [XLEN-1:0] pc_q, rs1_data_q, rs2_data_q, imm_q;
    logic [4:0]      rs1_q, rs2_q, rd_q;
    ctrl_t           ctrl_q;
    logic            illegal_q;

    assign opcode      = id_instr_i[6:0];
    assign rd_a        = id_instr_i[11:7];
    assign funct3      = id_instr_i[14:12];
    assign rs1_a       = id_instr_i[19:15];
    assign rs2_a       = id_instr_i[24:20];
    assign rf_raddr1_o = rs1_a;
    assign rf_raddr2_o = rs2_a;

    always_comb begin
        ctrl_d    = '0;
        imm_type  = IMM_I;
        illegal_d = 1'b0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        case (opcode)
            OPC_OP: begin
                ctrl_d.alu_op    = alu_op_from_funct(funct3, id_instr_i[30], 1'b1);
                ctrl_d.reg_write = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OPC_OP_IMM: begin
                ctrl_d.alu_op      = alu_op_from_funct(funct3, id_instr_i[30], 1'b0);
                ctrl_d.alu_src_imm = 1'b1;
                ctrl_d.reg_write   = 1'b1;
                use_rs1 = 1'b1;
            end
            OPC_LOAD: begin
                ctrl_d.alu_op      = ALU_ADD;
                ctrl_d.alu_src_imm = 1'b1;
                ctrl_d.mem_read    = 1'b1;
                ctrl_d.mem_size    = funct3;
                ctrl_d.reg_write   = 1'b1;
                ctrl_d.mem_to_reg  = 1'b1;
                use_rs1 = 1'b1;
            end
            OPC_STORE: begin
                ctrl_d.alu_op      = ALU_ADD;
                ctrl_d.alu_src_imm = 1'b1;
                ctrl_d.mem_write   = 1'b1;
                ctrl_d.mem_size    = funct3;
                imm_type = IMM_S;
                use_rs1  = 1'b1;
                use_rs2  = 1'b1;
            end
            OPC_BRANCH: begin
                ctrl_d.alu_op = ALU_SUB;
                ctrl_d.branch = 1'b1;
                imm_type = IMM_B;
                use_rs1  = 1'b1;
                use_rs2  = 1'b1;
            end
            OPC_JAL: begin
                ctrl_d.alu_op     = ALU_ADD;
                ctrl_d.alu_src_pc = 1'b1;
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.jump       = 1'b1;
                imm_type = IMM_J;
            end
            OPC_JALR: begin
                ctrl_d.alu_op      = ALU_ADD;
                ctrl_d.alu_src_imm = 1'b1;
                ctrl_d.reg_write   = 1'b1;
                ctrl_d.jump        = 1'b1;
                use_rs1 = 1'b1;
            end
            OPC_LUI: begin
                ctrl_d.alu_op      = ALU_PASSB;
                ctrl_d.alu_src_imm = 1'b1;
                ctrl_d.reg_write   = 1'b1;
                imm_type = IMM_U;
            end
            OPC_AUIPC: begin
                ctrl_d.alu_op      = ALU_ADD;
                ctrl_d.alu_src_pc  = 1'b1;
                ctrl_d.alu_src_imm = 1'b1;
                ctrl_d.reg_write   = 1'b1;
                imm_type = IMM_U;
            end
            default: illegal_d = 1'b1;
        endcase
        if (rd_a == 5'd0) ctrl_d.reg_write = 1'b0;
    end

    id_stage_imm_gen u_imm_gen (
        .instr_i    (id_instr_i[31:7]),
        .imm_type_i (imm_type),
        .imm_o      (imm32)
    );

    // Write-first bypass: the register file is written at the same edge
    // ID/EX loads, so its read data is one write stale.
    always_comb begin
        op1_d = rf_rdata1_i;
        op2_d = rf_rdata2_i;
        if (rs1_a == 5'd0)
            op1_d = '0;
        else if (wb_regwrite_i && wb_rd_i == rs1_a)
            op1_d = wb_wdata_i;
        if (rs2_a == 5'd0)
            op2_d = '0;
        else if (wb_regwrite_i && wb_rd_i == rs2_a)
            op2_d = wb_wdata_i;
    end

    assign load_use = id_valid_i && valid_q && ctrl_q.mem_read && rd_q != 5'd0 &&
                      ((use_rs1 && rs1_a == rd_q) || (use_rs2 && rs2_a == rd_q));

    assign if_stall_o = !flush_i && (ex_stall_i || load_use);

    // Bubbles (flush, load-use, invalid IF/ID) always carry ctrl=0.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            valid_q    <= 1'b0;
            pc_q       <= RST_PC;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            ctrl_q     <= '0;
            illegal_q  <= 1'b0;
        end else if (flush_i || (!ex_stall_i && load_use)) begin
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            illegal_q <= 1'b0;
        end else if (!ex_stall_i) begin
            valid_q    <= id_valid_i;
            pc_q       <= id_pc_i;
            rs1_data_q <= op1_d;
            rs2_data_q <= op2_d;
            imm_q      <= XLEN'($signed(imm32));
            rs1_q      <= rs1_a;
            rs2_q      <= rs2_a;
            rd_q       <= rd_a;
            ctrl_q     <= id_valid_i ? ctrl_d : '0;
            illegal_q  <= id_valid_i && illegal_d;
        end
    end

    assign ex.ex_valid_o    = valid_q;
    assign ex.ex_pc_o       = pc_q;
    assign ex.ex_rs1_data_o = rs1_data_q;
    assign ex.ex_rs2_data_o = rs2_data_q;
    assign ex.ex_imm_o      = imm_q;
    assign ex.ex_rs1_o      = rs1_q;
    assign ex.ex_rs2_o      = rs2_q;
    assign ex.ex_rd_o       = rd_q;
    assign ex.ex_ctrl_o     = ctrl_q;
    assign ex.ex_illegal_o  = illegal_q;
endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios followed by random
// instruction streams, compared against a behavioural model of ID/EX.
module tb_id_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        id_valid_i;
    logic [31:0] id_instr_i;
    logic [31:0] id_pc_i;
    logic [4:0]  rf_raddr1_o, rf_raddr2_o;
    logic [31:0] rf_rdata1_i, rf_rdata2_i;
    logic        wb_regwrite_i;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_wdata_i;
    logic        flush_i;
    logic        ex_stall_i;
    logic        if_stall_o;

    always #5 clk = ~clk;

    id_stage_if #(.XLEN(32)) exif ();

    id_stage #(.XLEN(32), .RST_PC(32'h0)) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .id_valid_i    (id_valid_i),
        .id_instr_i    (id_instr_i),
        .id_pc_i       (id_pc_i),
        .rf_raddr1_o   (rf_raddr1_o),
        .rf_raddr2_o   (rf_raddr2_o),
        .rf_rdata1_i   (rf_rdata1_i),
        .rf_rdata2_i   (rf_rdata2_i),
        .wb_regwrite_i (wb_regwrite_i),
        .wb_rd_i       (wb_rd_i),
        .wb_wdata_i    (wb_wdata_i),
        .flush_i       (flush_i),
        .ex_stall_i    (ex_stall_i),
        .if_stall_o    (if_stall_o),
        .ex            (exif)
    );

    typedef struct {
        bit          v;
        logic [31:0] pc, d1, d2, imm;
        logic [4:0]  rs1, rs2, rd;
        bit          rw, mr, mw, br, jp, si, ill, has_imm;
    } mdl_t;

    mdl_t m;
    int   n_tot = 0;
    int   n_bad = 0;
    bit   last_stall;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // Instruction class table: which sources are read, what control is set.
    task automatic ref_dec(input logic [31:0] i, output bit legal, u1, u2, rw, mr, mw,
                           br, jp, si, hi, output logic [31:0] imm);
        logic [31:0] sx;
        logic [6:0]  opc;
        sx  = i[31] ? 32'hFFFF_FFFF : 32'h0;
        opc = i[6:0];
        imm = (sx & 32'hFFFF_F000) | {20'h0, i[31:20]};
        case (opc)
            7'h33: {legal,u1,u2,rw,mr,mw,br,jp,si,hi} = 10'b1111000000;
            7'h13: {legal,u1,u2,rw,mr,mw,br,jp,si,hi} = 10'b1101000011;
            7'h03: {legal,u1,u2,rw,mr,mw,br,jp,si,hi} = 10'b1101100011;
            7'h23: begin
                {legal,u1,u2,rw,mr,mw,br,jp,si,hi} = 10'b1110010011;
                imm = (sx & 32'hFFFF_F000) | {20'h0, i[31:25], i[11:7]};
            end
            7'h63: begin
                {legal,u1,u2,rw,mr,mw,br,jp,si,hi} = 10'b1110001001;
                imm = (sx & 32'hFFFF_F000) | {20'h0, i[7], i[30:25], i[11:8], 1'b0};
            end
            7'h6F: begin
                {legal,u1,u2,rw,mr,mw,br,jp,si,hi} = 10'b1001000101;
                imm = (sx & 32'hFFF0_0000) | {12'h0, i[19:12], i[20], i[30:21], 1'b0};
            end
            7'h67: {legal,u1,u2,rw,mr,mw,br,jp,si,hi} = 10'b1101000111;
            7'h37, 7'h17: begin
                {legal,u1,u2,rw,mr,mw,br,jp,si,hi} = 10'b1001000011;
                imm = i & 32'hFFFF_F000;
            end
            default: {legal,u1,u2,rw,mr,mw,br,jp,si,hi} = 10'b0;
        endcase
        if (i[11:7] == 5'd0) rw = 1'b0;
    endtask

    function automatic logic [31:0] opnd(input logic [4:0] a, input logic [31:0] rf);
        if (a == 5'd0) return 32'h0;
        if (wb_regwrite_i && wb_rd_i == a) return wb_wdata_i;
        return rf;
    endfunction

    task automatic model_reset();
        m = '{default: '0};
    endtask

    task automatic check_out();
        chk("valid", 64'(exif.ex_valid_o), 64'(m.v));
        chk("pc", 64'(exif.ex_pc_o), 64'(m.pc));
        chk("illegal", 64'(exif.ex_illegal_o), 64'(m.ill));
        if (m.v) begin
            chk("rs1_data", 64'(exif.ex_rs1_data_o), 64'(m.d1));
            chk("rs2_data", 64'(exif.ex_rs2_data_o), 64'(m.d2));
            chk("rs1", 64'(exif.ex_rs1_o), 64'(m.rs1));
            chk("rs2", 64'(exif.ex_rs2_o), 64'(m.rs2));
            chk("rd", 64'(exif.ex_rd_o), 64'(m.rd));
            chk("reg_write", 64'(exif.ex_ctrl_o.reg_write), 64'(m.rw));
            chk("mem_read", 64'(exif.ex_ctrl_o.mem_read), 64'(m.mr));
            chk("mem_write", 64'(exif.ex_ctrl_o.mem_write), 64'(m.mw));
            chk("branch", 64'(exif.ex_ctrl_o.branch), 64'(m.br));
            chk("jump", 64'(exif.ex_ctrl_o.jump), 64'(m.jp));
            chk("alu_src_imm", 64'(exif.ex_ctrl_o.alu_src_imm), 64'(m.si));
            if (m.has_imm) chk("imm", 64'(exif.ex_imm_o), 64'(m.imm));
        end else begin
            chk("bubble_ctrl", 64'(exif.ex_ctrl_o), 64'h0);
        end
    endtask

    // Called just after a rising edge with inputs already set; checks the
    // combinational outputs, advances one clock and checks ID/EX.
    task automatic cycle();
        bit legal, u1, u2, rw, mr, mw, br, jp, si, hi, lu;
        logic [31:0] imm;
        ref_dec(id_instr_i, legal, u1, u2, rw, mr, mw, br, jp, si, hi, imm);
        #1;
        lu = id_valid_i && m.v && m.mr && m.rd != 5'd0 &&
             ((u1 && id_instr_i[19:15] == m.rd) || (u2 && id_instr_i[24:20] == m.rd));
        chk("raddr1", 64'(rf_raddr1_o), 64'(id_instr_i[19:15]));
        chk("raddr2", 64'(rf_raddr2_o), 64'(id_instr_i[24:20]));
        chk("if_stall", 64'(if_stall_o), 64'(!flush_i && (ex_stall_i || lu)));
        last_stall = if_stall_o;
        @(posedge clk);
        if (flush_i || (!ex_stall_i && lu)) begin
            m.v = 0; m.rw = 0; m.mr = 0; m.mw = 0; m.br = 0; m.jp = 0; m.si = 0; m.ill = 0;
        end else if (!ex_stall_i) begin
            m.v   = id_valid_i;
            m.pc  = id_pc_i;
            m.d1  = opnd(id_instr_i[19:15], rf_rdata1_i);
            m.d2  = opnd(id_instr_i[24:20], rf_rdata2_i);
            m.rs1 = id_instr_i[19:15];
            m.rs2 = id_instr_i[24:20];
            m.rd  = id_instr_i[11:7];
            m.imm = imm;
            m.has_imm = hi;
            m.rw  = id_valid_i && rw;
            m.mr  = id_valid_i && mr;
            m.mw  = id_valid_i && mw;
            m.br  = id_valid_i && br;
            m.jp  = id_valid_i && jp;
            m.si  = id_valid_i && si;
            m.ill = id_valid_i && !legal;
        end
        #1;
        check_out();
    endtask

    task automatic drive(input logic [31:0] instr, input logic v);
        id_instr_i = instr;
        id_valid_i = v;
        id_pc_i    = id_pc_i + 32'd4;
    endtask

    logic [6:0] opc_tab [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F,
                                 7'h67, 7'h37, 7'h17, 7'h0F, 7'h73};

    initial begin
        reset_i = 1'b1; id_valid_i = 1'b0; id_instr_i = '0; id_pc_i = 32'h100;
        rf_rdata1_i = '0; rf_rdata2_i = '0; wb_regwrite_i = 1'b0; wb_rd_i = '0;
        wb_wdata_i = '0; flush_i = 1'b0; ex_stall_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_out();
        chk("rst_ctrl", 64'(exif.ex_ctrl_o), 64'h0);
        chk("rst_if_stall", 64'(if_stall_o), 64'h0);
        reset_i = 1'b0;

        // ADDI x5,x0,-1
        drive(32'hFFF00293, 1'b1);
        cycle();
        chk("addi_imm", 64'(exif.ex_imm_o), 64'hFFFF_FFFF);
        chk("addi_rd", 64'(exif.ex_rd_o), 64'd5);
        chk("addi_rw", 64'(exif.ex_ctrl_o.reg_write), 64'd1);

        // ADDI x7,x3,0 with write-back to x3 in the same cycle
        drive(32'h00018393, 1'b1);
        rf_rdata1_i = 32'h11; wb_regwrite_i = 1'b1; wb_rd_i = 5'd3; wb_wdata_i = 32'hABCD;
        cycle();
        chk("bypass_hit", 64'(exif.ex_rs1_data_o), 64'hABCD);
        drive(32'h00018393, 1'b1);
        wb_rd_i = 5'd0;
        cycle();
        chk("bypass_x0", 64'(exif.ex_rs1_data_o), 64'h11);
        wb_regwrite_i = 1'b0;

        // LW x4,0(x1) ; ADD x6,x4,x2 -> one bubble then ADD
        drive(32'h0000A203, 1'b1);
        cycle();
        drive(32'h00220333, 1'b1);
        cycle();
        chk("lu_stall", 64'(last_stall), 64'd1);
        chk("lu_bubble", 64'(exif.ex_valid_o), 64'd0);
        cycle();
        chk("lu_release", 64'(last_stall), 64'd0);
        chk("lu_add_rd", 64'(exif.ex_rd_o), 64'd6);

        // LW x0 ; ADD x6,x0,x2 -> no stall, operand 0
        drive(32'h0000A003, 1'b1);
        cycle();
        drive(32'h00200333, 1'b1);
        rf_rdata1_i = 32'h55;
        cycle();
        chk("lwx0_nostall", 64'(last_stall), 64'd0);
        chk("lwx0_op", 64'(exif.ex_rs1_data_o), 64'd0);

        // load-use coinciding with flush
        drive(32'h0000A203, 1'b1);
        cycle();
        drive(32'h00220333, 1'b1);
        flush_i = 1'b1;
        cycle();
        chk("flush_stall", 64'(last_stall), 64'd0);
        chk("flush_valid", 64'(exif.ex_valid_o), 64'd0);
        flush_i = 1'b0;

        // EX stall for 3 cycles, then asynchronous reset mid-stall
        drive(32'hFFF00293, 1'b1);
        cycle();
        ex_stall_i = 1'b1;
        drive(32'h00100513, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("stall_held", 64'(last_stall), 64'd1);
            chk("stall_rd", 64'(exif.ex_rd_o), 64'd5);
        end
        #2 reset_i = 1'b1;
        #1;
        model_reset();
        check_out();
        chk("async_rd", 64'(exif.ex_rd_o), 64'd0);
        chk("async_imm", 64'(exif.ex_imm_o), 64'd0);
        #1 reset_i = 1'b0;
        ex_stall_i = 1'b0;
        id_valid_i = 1'b0;
        cycle();

        // Random streams, register indices concentrated to provoke hazards
        for (int n = 0; n < 600; n++) begin
            logic [31:0] ins;
            ins = $urandom;
            ins[6:0]   = opc_tab[$urandom_range(0, 10)];
            ins[11:7]  = 5'($urandom_range(0, 3));
            ins[19:15] = 5'($urandom_range(0, 3));
            ins[24:20] = 5'($urandom_range(0, 3));
            drive(ins, $urandom_range(0, 9) < 8);
            id_pc_i       = $urandom;
            rf_rdata1_i   = $urandom;
            rf_rdata2_i   = $urandom;
            wb_regwrite_i = $urandom_range(0, 1) == 1;
            wb_rd_i       = 5'($urandom_range(0, 3));
            wb_wdata_i    = $urandom;
            flush_i       = $urandom_range(0, 9) == 0;
            ex_stall_i    = $urandom_range(0, 19) < 3;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
